// File: rtl/chip_check_pkg.sv
// Shared definitions for the 74xx socket tester: chip codes, socket pin order
// and the per-vector table entry returned by chip_vector_rom.
package chip_check_pkg;

  localparam int PIN_W = 12;

  typedef enum logic [3:0] {
    CHIP_7400 = 4'd0,
    CHIP_7402 = 4'd1,
    CHIP_7404 = 4'd2,
    CHIP_7408 = 4'd3
  } chip_code_e;

  // Bit positions of the socket pins; pins 7 and 14 are the supply and never appear.
  localparam int PIN1  = 0;
  localparam int PIN2  = 1;
  localparam int PIN3  = 2;
  localparam int PIN4  = 3;
  localparam int PIN5  = 4;
  localparam int PIN6  = 5;
  localparam int PIN8  = 6;
  localparam int PIN9  = 7;
  localparam int PIN10 = 8;
  localparam int PIN11 = 9;
  localparam int PIN12 = 10;
  localparam int PIN13 = 11;

  typedef struct packed {
    logic [PIN_W-1:0] drive;
    logic [PIN_W-1:0] outmask;
    logic [PIN_W-1:0] expected;
    logic             last;
    logic             valid;
  } vec_entry_t;

  // Quad 2-input gates (7400 / 7408) share one pinout.
  localparam logic [PIN_W-1:0] M7400_A = (12'd1 << PIN1) | (12'd1 << PIN4) | (12'd1 << PIN9)  | (12'd1 << PIN12);
  localparam logic [PIN_W-1:0] M7400_B = (12'd1 << PIN2) | (12'd1 << PIN5) | (12'd1 << PIN10) | (12'd1 << PIN13);
  localparam logic [PIN_W-1:0] M7400_Y = (12'd1 << PIN3) | (12'd1 << PIN6) | (12'd1 << PIN8)  | (12'd1 << PIN11);

  // 7402 puts the outputs on the outer pins of each gate group.
  localparam logic [PIN_W-1:0] M7402_A = (12'd1 << PIN2) | (12'd1 << PIN5) | (12'd1 << PIN8)  | (12'd1 << PIN11);
  localparam logic [PIN_W-1:0] M7402_B = (12'd1 << PIN3) | (12'd1 << PIN6) | (12'd1 << PIN9)  | (12'd1 << PIN12);
  localparam logic [PIN_W-1:0] M7402_Y = (12'd1 << PIN1) | (12'd1 << PIN4) | (12'd1 << PIN10) | (12'd1 << PIN13);

  localparam logic [PIN_W-1:0] M7404_A = (12'd1 << PIN1) | (12'd1 << PIN3) | (12'd1 << PIN5) |
                                         (12'd1 << PIN9) | (12'd1 << PIN11) | (12'd1 << PIN13);
  localparam logic [PIN_W-1:0] M7404_Y = (12'd1 << PIN2) | (12'd1 << PIN4) | (12'd1 << PIN6) |
                                         (12'd1 << PIN8) | (12'd1 << PIN10) | (12'd1 << PIN12);

endpackage

// File: rtl/chip_vector_rom.sv
// Combinational vector table: (chip_sel, idx) -> drive/mask/expect entry.
// All gates of a chip are exercised in parallel with the same input pattern.
import chip_check_pkg::*;

module chip_vector_rom #(
  parameter int VEC_AW = 5
) (
  input  logic [3:0]        chip_sel,
  input  logic [VEC_AW-1:0] idx,
  output vec_entry_t        entry
);

  logic a;
  logic b;
  logic y;

  always_comb begin
    entry = '0;
    a     = idx[1];
    b     = idx[0];
    y     = 1'b0;
    case (chip_sel)
      CHIP_7400, CHIP_7408: begin
        if (int'(idx) < 4) begin
          y              = (chip_sel == CHIP_7400) ? ~(a & b) : (a & b);
          entry.valid    = 1'b1;
          entry.last     = (int'(idx) == 3);
          entry.outmask  = M7400_Y;
          entry.drive    = ({PIN_W{a}} & M7400_A) | ({PIN_W{b}} & M7400_B);
          entry.expected = {PIN_W{y}} & M7400_Y;
        end
      end
      CHIP_7402: begin
        if (int'(idx) < 4) begin
          y              = ~(a | b);
          entry.valid    = 1'b1;
          entry.last     = (int'(idx) == 3);
          entry.outmask  = M7402_Y;
          entry.drive    = ({PIN_W{a}} & M7402_A) | ({PIN_W{b}} & M7402_B);
          entry.expected = {PIN_W{y}} & M7402_Y;
        end
      end
      CHIP_7404: begin
        // Single-input part: only two patterns, driven from idx[0].
        if (int'(idx) < 2) begin
          y              = ~b;
          entry.valid    = 1'b1;
          entry.last     = (int'(idx) == 1);
          entry.outmask  = M7404_Y;
          entry.drive    = {PIN_W{b}} & M7404_A;
          entry.expected = {PIN_W{y}} & M7404_Y;
        end
      end
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/chip_test_sequencer.sv
// Socket test sequencer: applies each table vector, waits SETTLE_CYCLES, samples outputs.
// Define STOP_ON_FAIL_EN to end the run at the first mismatching vector.
import chip_check_pkg::*;

module chip_test_sequencer #(
  parameter int SETTLE_CYCLES = 50,
  parameter int VEC_AW        = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [3:0]        chip_sel,
  input  logic [11:0]       pin_in,
  output logic [11:0]       pin_out,
  output logic [11:0]       pin_oe,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              unsupported,
  output logic [7:0]        err_cnt,
  output logic [VEC_AW-1:0] fail_idx
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] APPLY  = 3'd1;
  localparam logic [2:0] SETTLE = 3'd2;
  localparam logic [2:0] SAMPLE = 3'd3;
  localparam logic [2:0] NEXT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [2:0]        state;
  logic [3:0]        chip_r;
  logic [VEC_AW-1:0] idx;
  logic [CNT_W-1:0]  cnt;
  vec_entry_t        entry;
  logic              mismatch;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  chip_vector_rom #(.VEC_AW(VEC_AW)) u_rom (
    .chip_sel (chip_r),
    .idx      (idx),
    .entry    (entry)
  );

  assign mismatch = |((pin_in ^ entry.expected) & entry.outmask);
  assign busy     = (state == APPLY) || (state == SETTLE) || (state == SAMPLE) || (state == NEXT);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state       <= IDLE;
      chip_r      <= '0;
      idx         <= '0;
      cnt         <= '0;
      pin_out     <= '0;
      pin_oe      <= '0;
      done        <= 1'b0;
      pass        <= 1'b0;
      unsupported <= 1'b0;
      err_cnt     <= '0;
      fail_idx    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            chip_r      <= chip_sel;
            idx         <= '0;
            err_cnt     <= '0;
            fail_idx    <= '0;
            done        <= 1'b0;
            pass        <= 1'b0;
            unsupported <= 1'b0;
            state       <= APPLY;
          end
        end
        APPLY: begin
          if (!entry.valid) begin
            unsupported <= 1'b1;
            pass        <= 1'b0;
            done        <= 1'b1;
            pin_oe      <= '0;
            state       <= DONE;
          end else begin
            pin_out <= entry.drive;
            pin_oe  <= ~entry.outmask;
            cnt     <= CNT_W'(SETTLE_CYCLES - 1);
            state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (cnt == '0) state <= SAMPLE;
          else           cnt   <= cnt - 1'b1;
        end
        SAMPLE: begin
          state <= NEXT;
          if (mismatch) begin
            if (err_cnt == '0) fail_idx <= idx;
`ifdef STOP_ON_FAIL_EN
            err_cnt <= 8'd1;
            pass    <= 1'b0;
            done    <= 1'b1;
            pin_oe  <= '0;
            state   <= DONE;
`else
            err_cnt <= sat_inc(err_cnt);
`endif
          end
        end
        NEXT: begin
          // An all-ones idx without a last marker means the table ran away.
          if (entry.last || (idx == '1)) begin
            done   <= 1'b1;
            pass   <= entry.last && (err_cnt == '0) && !unsupported;
            pin_oe <= '0;
            state  <= DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= APPLY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chip_test_sequencer.sv
// Randomized bench for chip_test_sequencer with a behavioural 74xx socket model.
module tb_chip_test_sequencer;

  localparam int S  = 5;
  localparam int AW = 5;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic [3:0]    chip_sel = '0;
  logic [11:0]   pin_in;
  logic [11:0]   pin_out;
  logic [11:0]   pin_oe;
  logic          busy;
  logic          done;
  logic          pass;
  logic          unsupported;
  logic [7:0]    err_cnt;
  logic [AW-1:0] fail_idx;

  always #5 Clk = ~Clk;

  chip_test_sequencer #(.SETTLE_CYCLES(S), .VEC_AW(AW)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .chip_sel    (chip_sel),
    .pin_in      (pin_in),
    .pin_out     (pin_out),
    .pin_oe      (pin_oe),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .unsupported (unsupported),
    .err_cnt     (err_cnt),
    .fail_idx    (fail_idx)
  );

  int total = 0;
  int bad   = 0;
  int viol  = 0;

  logic [3:0]  cur_chip = 4'hF;
  logic [11:0] smask = '0;
  logic [11:0] sval  = '0;
  logic [11:0] noise = '0;

  // Datasheet pin numbers per gate: {A, B, Y} or {A, Y}.
  localparam int NAND_P [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{9, 10, 8}, '{12, 13, 11}};
  localparam int NOR_P  [4][3] = '{'{2, 3, 1}, '{5, 6, 4}, '{8, 9, 10}, '{11, 12, 13}};
  localparam int INV_P  [6][2] = '{'{1, 2}, '{3, 4}, '{5, 6}, '{9, 8}, '{11, 10}, '{13, 12}};

  function automatic int pb(input int pin);
    return (pin <= 6) ? pin - 1 : pin - 2;
  endfunction

  function automatic int ngates(input int chip);
    return (chip == 2) ? 6 : 4;
  endfunction

  function automatic int pin_of(input int chip, input int g, input int k);
    if (chip == 2) return INV_P[g][k];
    if (chip == 1) return NOR_P[g][k];
    return NAND_P[g][k];
  endfunction

  function automatic int out_pin(input int chip, input int g);
    return pin_of(chip, g, (chip == 2) ? 1 : 2);
  endfunction

  function automatic logic gate(input int chip, input logic a, input logic b);
    case (chip)
      0:       return ~(a & b);
      1:       return ~(a | b);
      3:       return a & b;
      default: return ~a;
    endcase
  endfunction

  function automatic logic [11:0] out_mask(input int chip);
    logic [11:0] m;
    if (chip > 3) return 12'hFFF;
    m = '0;
    for (int g = 0; g < ngates(chip); g++) m[pb(out_pin(chip, g))] = 1'b1;
    return m;
  endfunction

  function automatic logic [11:0] socket(input int chip, input logic [11:0] pout, input logic [11:0] poe,
                                         input logic [11:0] sm, input logic [11:0] sv, input logic [11:0] nz);
    logic [11:0] r;
    logic a, b;
    r = pout & poe;
    if (chip <= 3) begin
      for (int g = 0; g < ngates(chip); g++) begin
        a = r[pb(pin_of(chip, g, 0))];
        b = (chip == 2) ? 1'b0 : r[pb(pin_of(chip, g, 1))];
        r[pb(out_pin(chip, g))] = gate(chip, a, b);
      end
    end else begin
      r = nz;
    end
    return (r & ~sm) | (sv & sm);
  endfunction

  always_comb pin_in = socket(int'(cur_chip), pin_out, pin_oe, smask, sval, noise);

  // Contention / idle-drive watcher: socket outputs must never be driven.
  always @(negedge Clk) begin
    if (!Reset) begin
      if ((pin_oe & out_mask(int'(cur_chip))) != '0) viol++;
      if (!busy && (pin_oe != '0)) viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected outcome of a full run, from the gate truth tables and the stuck pins.
  task automatic model(input int chip, input logic [11:0] sm, input logic [11:0] sv,
                       output int e_err, output int e_fidx, output int e_pass,
                       output int e_unsup, output int e_busy);
    int nv;
    logic a, b, ideal, seen, vbad;
    e_err = 0; e_fidx = 0; e_pass = 0; e_unsup = 0;
    if (chip > 3) begin
      e_unsup = 1;
      e_busy  = 1;
      return;
    end
    nv     = (chip == 2) ? 2 : 4;
    e_busy = nv * (S + 3);
    for (int v = 0; v < nv; v++) begin
      a = (chip == 2) ? v[0] : v[1];
      b = v[0];
      vbad = 1'b0;
      for (int g = 0; g < ngates(chip); g++) begin
        ideal = gate(chip, a, b);
        seen  = sm[pb(out_pin(chip, g))] ? sv[pb(out_pin(chip, g))] : ideal;
        if (seen != ideal) vbad = 1'b1;
      end
      if (vbad) begin
        if (e_err == 0) e_fidx = v;
        e_err++;
`ifdef STOP_ON_FAIL_EN
        e_busy = v * (S + 3) + S + 2;
        break;
`endif
      end
    end
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".done"}, done, 0);
    chk({tag, ".pass"}, pass, 0);
    chk({tag, ".unsup"}, unsupported, 0);
    chk({tag, ".err_cnt"}, err_cnt, 0);
    chk({tag, ".fail_idx"}, fail_idx, 0);
    chk({tag, ".pin_oe"}, pin_oe, 0);
    chk({tag, ".pin_out"}, pin_out, 0);
  endtask

  task automatic run(input logic [3:0] chip, input logic [11:0] sm, input logic [11:0] sv,
                     input int stray_at, input string tag);
    int e_err, e_fidx, e_pass, e_unsup, e_busy;
    int bcnt, cyc, v0;
    model(int'(chip), sm, sv, e_err, e_fidx, e_pass, e_unsup, e_busy);
    cur_chip = chip; smask = sm; sval = sv; noise = 12'($urandom);
    v0 = viol;
    @(negedge Clk);
    chip_sel = chip;
    Start    = 1'b1;
    @(negedge Clk);
    Start    = 1'b0;
    chip_sel = 4'($urandom);
    bcnt = 0; cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      if (busy) bcnt++;
      Start = busy && (bcnt == stray_at);
      @(negedge Clk);
      cyc++;
    end
    Start = 1'b0;
    chk({tag, ".finished"}, (cyc < 200), 1);
    chk({tag, ".done"}, done, 1);
    chk({tag, ".pass"}, pass, e_pass);
    chk({tag, ".unsup"}, unsupported, e_unsup);
    chk({tag, ".err_cnt"}, err_cnt, e_err);
    chk({tag, ".fail_idx"}, fail_idx, e_fidx);
    chk({tag, ".busy_cycles"}, bcnt, e_busy);
    chk({tag, ".pin_oe"}, pin_oe, 0);
    repeat (3) @(negedge Clk);
    chk({tag, ".done_held"}, done, 1);
    chk({tag, ".oe_violations"}, viol - v0, 0);
  endtask

  initial begin
    int c, g, stray, bcnt, cyc;
    logic [3:0]  chip;
    logic [11:0] sm, sv, rsm;

    Reset = 1'b1;
    repeat (3) @(negedge Clk);
    check_reset_state("reset");

    // Reset wins over a simultaneous Start.
    chip_sel = 4'd0;
    Start    = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    chk("rst_prio.busy", busy, 0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_prio.idle", busy, 0);

    run(4'd0, 12'h000, 12'h000, 0, "nand_ok");
    run(4'd0, 12'd1 << pb(3), 12'h000, 0, "nand_pin3_stuck0");
    run(4'd15, 12'h000, 12'h000, 0, "unsup15");
    run(4'd0, 12'h000, 12'h000, S + 5, "stray_start");
    run(4'd1, 12'h000, 12'h000, 0, "nor_ok");
    run(4'd2, 12'h000, 12'h000, 0, "inv_ok");
    run(4'd3, 12'h000, 12'h000, 0, "and_ok");

    // Reset in the SETTLE phase of vector 2.
`ifdef STOP_ON_FAIL_EN
    rsm = 12'h000;
`else
    rsm = 12'd1 << pb(3);
`endif
    cur_chip = 4'd0; smask = rsm; sval = '0;
    @(negedge Clk);
    chip_sel = 4'd0;
    Start    = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    bcnt = 0; cyc = 0;
    while (cyc < 200) begin
      if (busy) bcnt++;
      if (bcnt == 2 * (S + 3) + 2) break;
      @(negedge Clk);
      cyc++;
    end
    chk("rst_mid.reached", bcnt, 2 * (S + 3) + 2);
    Reset = 1'b1;
    @(negedge Clk);
    check_reset_state("rst_mid");
    Reset = 1'b0;
    run(4'd0, rsm, 12'h000, 0, "rerun");

    for (int i = 0; i < 24; i++) begin
      c    = $urandom_range(0, 5);
      chip = (c > 3) ? 4'($urandom_range(4, 15)) : 4'(c);
      sm   = '0;
      sv   = '0;
      if (chip <= 4'd3 && $urandom_range(0, 1) == 1) begin
        g  = $urandom_range(0, ngates(int'(chip)) - 1);
        sm = 12'd1 << pb(out_pin(int'(chip), g));
        sv = ($urandom_range(0, 1) == 1) ? sm : 12'h000;
      end
      stray = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 8) : 0;
      run(chip, sm, sv, stray, "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
